// File: rtl/rom_pixel_streamer_pkg.sv
// Shared constants and the FSM state type for the ROM pixel streamer.
package rom_stream_pkg;
   localparam int IMG_BYTES_DFLT = 307200;
   localparam int ADDR_W_DFLT    = 19;
   localparam int BURST_BYTES    = 20;
   localparam int BURST_WORDS    = 10;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} rps_state_t;
endpackage

// File: rtl/rom_pixel_streamer_if.sv
// ROM read bus plus valid/ready pixel stream; master is the streamer side.
interface rom_pixel_streamer_if #(parameter int ADDR_W = 19);
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data1, rom_data2, rom_data3, rom_data4, rom_data5;
   logic [15:0]       rom_data6, rom_data7, rom_data8, rom_data9, rom_data10;
   logic [7:0]        pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_last;

   modport master (
      output rom_addr, pix_data, pix_valid, pix_last,
      input  rom_data1, rom_data2, rom_data3, rom_data4, rom_data5,
             rom_data6, rom_data7, rom_data8, rom_data9, rom_data10, pix_ready
   );

   modport slave (
      input  rom_addr, pix_data, pix_valid, pix_last,
      output rom_data1, rom_data2, rom_data3, rom_data4, rom_data5,
             rom_data6, rom_data7, rom_data8, rom_data9, rom_data10, pix_ready
   );
endinterface

// File: rtl/rom_pixel_streamer_burst_serializer.sv
// Burst register: loads one ROM burst and shifts it out MSB byte first,
// counting bytes so the FSM knows when the burst is exhausted.
module burst_serializer
   import rom_stream_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_load,
   input  logic                     i_shift,
   input  logic [BURST_BYTES*8-1:0] i_burst,
   output logic [7:0]               o_byte,
   output logic                     o_last_byte
);
   logic [BURST_BYTES*8-1:0] r_burst;
   logic [4:0]               r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_burst <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_burst <= i_burst;
         r_cnt   <= '0;
      end else if (i_shift) begin
         r_burst <= {r_burst[BURST_BYTES*8-9:0], 8'h00};
         r_cnt   <= r_cnt + 5'd1;
      end
   end

   assign o_byte      = r_burst[BURST_BYTES*8-1 -: 8];
   assign o_last_byte = (r_cnt == 5'(BURST_BYTES-1));
endmodule

// File: rtl/rom_pixel_streamer.sv
// Walks the image ROM in 20-byte bursts and streams bytes over valid/ready.
// Define RPS_CHECKSUM_EN to add a 16-bit running sum of accepted bytes.
module rom_pixel_streamer
   import rom_stream_pkg::*;
#(
   parameter int IMG_BYTES = IMG_BYTES_DFLT,
   parameter int ADDR_W    = ADDR_W_DFLT
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   rom_pixel_streamer_if.master io_bus,
   output logic                 o_busy,
   output logic                 o_done
`ifdef RPS_CHECKSUM_EN
   ,
   output logic [15:0]          o_checksum
`endif
);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_BYTES - BURST_BYTES);
   localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_BYTES);

   rps_state_t        r_state, w_next;
   logic [ADDR_W-1:0] r_rom_addr;
   logic              w_load, w_shift, w_hs, w_final, w_last_byte;
   logic [7:0]        w_byte;
   logic [BURST_BYTES*8-1:0] w_burst;

   assign w_burst = {io_bus.rom_data1, io_bus.rom_data2, io_bus.rom_data3, io_bus.rom_data4,
                     io_bus.rom_data5, io_bus.rom_data6, io_bus.rom_data7, io_bus.rom_data8,
                     io_bus.rom_data9, io_bus.rom_data10};

   // valid comes only from registered state, so ready never reaches valid/data combinationally
   assign w_hs    = (r_state == DRAIN) && io_bus.pix_ready;
   assign w_final = (r_rom_addr == LAST_ADDR);

   burst_serializer u_ser (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_shift     (w_shift),
      .i_burst     (w_burst),
      .o_byte      (w_byte),
      .o_last_byte (w_last_byte)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      case (r_state)
         IDLE:  if (i_start) w_next = FETCH;
         FETCH: begin
            w_load = 1'b1;
            w_next = DRAIN;
         end
         DRAIN: if (w_hs) begin
            w_shift = 1'b1;
            if (w_last_byte) w_next = w_final ? DONE : FETCH;
         end
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_rom_addr <= '0;
      else if ((r_state == IDLE) && i_start)
         r_rom_addr <= '0;
      else if (w_shift && w_last_byte && !w_final)
         r_rom_addr <= r_rom_addr + BURST_STEP;
   end

`ifdef RPS_CHECKSUM_EN
   logic [15:0] r_checksum;
   always_ff @(posedge clk) begin
      if (rst)
         r_checksum <= '0;
      else if ((r_state == IDLE) && i_start)
         r_checksum <= '0;
      else if (w_hs)
         r_checksum <= r_checksum + {8'h00, w_byte};
   end
   assign o_checksum = r_checksum;
`endif

   assign io_bus.rom_addr  = r_rom_addr;
   assign io_bus.pix_data  = w_byte;
   assign io_bus.pix_valid = (r_state == DRAIN);
   assign io_bus.pix_last  = (r_state == DRAIN) && w_last_byte && w_final;
   assign o_busy           = (r_state != IDLE);
   assign o_done           = (r_state == DONE);
endmodule

// File: tb/tb_rom_pixel_streamer.sv
// Bench for rom_pixel_streamer on a reduced 5120-byte image with rom[i] = i mod 256.
module tb_rom_pixel_streamer;
   import rom_stream_pkg::*;

   localparam int TB_IMG = 5120;
   localparam int AW     = 19;
   localparam int BUDGET = 40000;

   logic clk = 1'b0;
   logic rst, start, busy, done;
`ifdef RPS_CHECKSUM_EN
   logic [15:0] checksum;
`endif
   int total = 0;
   int bad   = 0;

   rom_pixel_streamer_if #(.ADDR_W(AW)) bus ();

   rom_pixel_streamer #(.IMG_BYTES(TB_IMG), .ADDR_W(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_start (start),
      .io_bus  (bus),
      .o_busy  (busy),
      .o_done  (done)
`ifdef RPS_CHECKSUM_EN
      ,
      .o_checksum (checksum)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rw(input logic [AW-1:0] a, input int n);
      int b;
      b = int'(a) + 2*n - 2;
      return {8'(b), 8'(b + 1)};
   endfunction

   assign bus.rom_data1  = rw(bus.rom_addr, 1);
   assign bus.rom_data2  = rw(bus.rom_addr, 2);
   assign bus.rom_data3  = rw(bus.rom_addr, 3);
   assign bus.rom_data4  = rw(bus.rom_addr, 4);
   assign bus.rom_data5  = rw(bus.rom_addr, 5);
   assign bus.rom_data6  = rw(bus.rom_addr, 6);
   assign bus.rom_data7  = rw(bus.rom_addr, 7);
   assign bus.rom_data8  = rw(bus.rom_addr, 8);
   assign bus.rom_data9  = rw(bus.rom_addr, 9);
   assign bus.rom_data10 = rw(bus.rom_addr, 10);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit         st;
      bit         rdy;
      bit         v;
      bit         b;
      bit         cd;
      logic [7:0] d;
      int         a;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit st, input bit rdy, input bit v, input bit b,
                      input bit cd, input int d, input int a);
      vec_t e;
      e = '{st, rdy, v, b, cd, 8'(d), a};
      tbl.push_back(e);
   endtask

   // Reference: byte k of the pass is k mod 256, fetched from burst address (k/20)*20.
   task automatic run_pass(input bit rnd);
      int k = 0, c = 0, c_first, c_last = -1, errs = 0, lasts = 0, dones = 0;
      int last_addr = -1;
      logic [7:0] last_data = 8'h00;
      bit fin = 0;
      start = 1'b1;
      bus.pix_ready = 1'b1;
      tick();
      c++;
      start = 1'b0;
      c_first = c;
      check("pass_busy_after_start", 32'(busy), 32'd1);
`ifdef RPS_CHECKSUM_EN
      check("pass_checksum_cleared", 32'(checksum), 32'd0);
`endif
      while (!fin && c < BUDGET) begin
         bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done) dones++;
         if (bus.pix_valid && bus.pix_ready) begin
            if (bus.pix_data !== 8'(k)) errs++;
            if (int'(bus.rom_addr) != (k / 20) * 20) errs++;
            if (bus.pix_last) lasts++;
            if (bus.pix_last !== (k == TB_IMG - 1)) errs++;
            if (k == TB_IMG - 1) begin
               last_data = bus.pix_data;
               last_addr = int'(bus.rom_addr);
               c_last    = c;
               fin       = 1'b1;
            end
            k++;
         end
         tick();
         c++;
      end
      check("pass_handshakes", 32'(k), 32'(TB_IMG));
      check("pass_stream_errs", 32'(errs), 32'd0);
      check("pass_last_count", 32'(lasts), 32'd1);
      check("pass_final_byte", 32'(last_data), 32'hFF);
      check("pass_final_addr", 32'(last_addr), 32'(TB_IMG - 20));
      if (!rnd) check("pass_cycles", 32'(c_last - c_first + 1), 32'(TB_IMG / 20 * 21));
      check("pass_done_hi", 32'(done), 32'd1);
      check("pass_valid_lo_done", 32'(bus.pix_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         if (done) dones++;
         tick();
         if (i == 0) check("pass_busy_idle", 32'(busy), 32'd0);
      end
      check("pass_done_pulses", 32'(dones), 32'd1);
`ifdef RPS_CHECKSUM_EN
      check("pass_checksum", 32'(checksum), 32'hF600);
`endif
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      bus.pix_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(bus.pix_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(bus.rom_addr), 32'd0);
      check("rst_data", 32'(bus.pix_data), 32'd0);
      check("rst_last", 32'(bus.pix_last), 32'd0);
      rst = 1'b0;

      // first burst with a 3-cycle stall on 0x05 and an ignored start at byte 9
      add(0, 1, 0, 0, 1, 0, 0);
      add(1, 1, 0, 1, 0, 0, 0);
      add(0, 1, 1, 1, 1, 0, 0);
      for (int k = 1; k <= 5; k++) add(0, 1, 1, 1, 1, k, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 1, 5, 0);
      for (int k = 6; k <= 19; k++) add(k == 10, 1, 1, 1, 1, k, 0);
      add(0, 1, 0, 1, 0, 0, 20);
      add(0, 1, 1, 1, 1, 8'h14, 20);

      foreach (tbl[i]) begin
         start = tbl[i].st;
         bus.pix_ready = tbl[i].rdy;
         tick();
         check($sformatf("tbl%0d_valid", i), 32'(bus.pix_valid), 32'(tbl[i].v));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
         check($sformatf("tbl%0d_addr", i), 32'(bus.rom_addr), 32'(tbl[i].a));
         check($sformatf("tbl%0d_last", i), 32'(bus.pix_last), 32'd0);
         if (tbl[i].cd) check($sformatf("tbl%0d_data", i), 32'(bus.pix_data), 32'(tbl[i].d));
      end
      start = 1'b0;

      // run on to byte 7 of the third burst, then reset mid-pass
      bus.pix_ready = 1'b1;
      n = 0;
      while (!(bus.pix_valid && bus.pix_data == 8'h2F && bus.rom_addr == 19'd40) && n < 200) begin
         tick();
         n++;
      end
      check("reach_burst3_byte7", 32'(n < 200), 32'd1);
      rst = 1'b1;
      tick();
      check("midrst_valid", 32'(bus.pix_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_addr", 32'(bus.rom_addr), 32'd0);
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("restart_valid", 32'(bus.pix_valid), 32'd1);
      check("restart_data", 32'(bus.pix_data), 32'd0);
      check("restart_addr", 32'(bus.rom_addr), 32'd0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      run_pass(1'b0);
      run_pass(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rom_pixel_streamer.md
# rom_pixel_streamer

Sequencer and serializer downstream of the image ROM: walks the 640x480 8-bit image (307200 bytes) in 20-byte bursts and captures the ROM's ten 16-bit words per burst. It emits the bytes one per handshake on a valid/ready pixel stream toward the processing pipeline. It owns the ROM address and is the only driver of it.

## Interface
- IMG_BYTES, 307200: image size in bytes; must be a multiple of 20.
- ADDR_W, 19: ROM byte-address width.
- clk  in  1  clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a full-image pass; sampled only in IDLE.
- rom_addr  out  ADDR_W  byte address to ROM; reset 0.
- rom_data1 .. rom_data10  in  16 each  ROM words; dataN = {rom[addr+2N-2], rom[addr+2N-1]}.
- pix_data  out  8  current byte; reset 0x00.
- pix_valid  out  1  byte available; reset 0.
- pix_ready  in  1  consumer accepts byte.
- pix_last  out  1  qualifies the final image byte (byte IMG_BYTES-1); reset 0.
- busy  out  1  high outside IDLE; reset 0.
- done  out  1  one-cycle pulse after final handshake; reset 0.

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE. Reset -> IDLE, rom_addr=0, byte count=0, all outputs at reset values.
- IDLE: start=1 -> FETCH, rom_addr<=0.
- FETCH (1 cycle): ROM is combinational. Load rom_data1..10 into a 160-bit burst register, rom_data1 in the most significant position. Clear byte count -> DRAIN.
- DRAIN: pix_valid=1, pix_data = burst register [159:152]. On pix_valid&pix_ready: shift left 8 and increment count.
  - Handshake at count 19 with rom_addr+20 == IMG_BYTES -> DONE.
  - Handshake at count 19 otherwise -> rom_addr+=20, FETCH.
- Byte order: rom[addr], rom[addr+1], ..., rom[addr+19], i.e. the high byte of each word first.
- pix_last = pix_valid & (count==19) & (rom_addr == IMG_BYTES-20).
- DONE (1 cycle): done=1, pix_valid=0, rom_addr held -> IDLE.
- Backpressure: while pix_valid & !pix_ready, pix_data and pix_last hold stable. pix_valid never drops before the handshake.
- start while busy is ignored. start in the DONE cycle is ignored.
- rst mid-pass: next cycle IDLE, pix_valid=0, busy=0, rom_addr=0. The partial burst is discarded.
- Address arithmetic is unsigned in ADDR_W bits and never wraps, because it stops at IMG_BYTES-20.

## Timing
- start sampled at edge 0 -> FETCH during cycle 1 -> first pix_valid in cycle 2.
- With pix_ready held high: 1 byte/cycle inside a burst and one bubble cycle (FETCH) between bursts. This gives 21 cycles per burst and IMG_BYTES/20*21 = 322560 cycles from first FETCH to last handshake.
- done asserts in the cycle after the pix_last handshake. busy falls with the return to IDLE one cycle later.
- No combinational path from pix_ready to pix_valid or pix_data.

## Configuration
- RPS_CHECKSUM_EN defined:
  - Adds output checksum [15:0] (reset 0), cleared on accepted start.
  - Each pixel handshake adds pix_data, modulo 2^16.
  - Value is held after done until the next start or rst.
- RPS_CHECKSUM_EN undefined: no checksum port and no adder; all other behaviour is identical.

## Structure
- Package rom_stream_pkg holds:
  - IMG_BYTES default.
  - BURST_BYTES=20 and BURST_WORDS=10.
  - typedef enum logic [1:0] rps_state_t {IDLE, FETCH, DRAIN, DONE}.
- One sub-module, burst_serializer: the 160-bit load/shift register plus 5-bit byte counter, with load, shift and last_byte signals. The top module holds the FSM, address counter and optional checksum.

## Test plan
ROM image is rom[i] = i mod 256.
- Reset, pulse start, pix_ready=1 -> pix_valid first high 2 cycles after start. Bytes are 0x00..0x13, then pix_valid low for 1 cycle, then 0x14 with rom_addr=20.
- pix_ready=0 for 3 cycles while pix_data=0x05 -> pix_data stays 0x05 with pix_valid=1. Stream resumes with 0x06 and no byte is lost or duplicated.
- Full pass with ready=1:
  - Final byte 0xFF arrives with pix_last=1 and rom_addr=307180.
  - done pulses exactly once, 1 cycle later.
  - Exactly 307200 handshakes in 322560 cycles.
- start pulsed mid-pass -> ignored and byte sequence unaffected. rst during byte 7 of burst 3 -> next cycle pix_valid=0, busy=0, rom_addr=0. A new start restarts at 0x00.
- Random pix_ready (50%) over a full pass -> output byte k equals k mod 256 for all k and pix_last appears only on k=307199.
- With RPS_CHECKSUM_EN: after a full pass checksum = 0xA800. A second start clears it to 0 and the second pass ends again at 0xA800.
